fp_loader: RTL and testbench

//  Drives the SAP-1 front-panel programming interface (fp_prog/fp_write/fp_adr/fp_data/fp_clear) from a

---
 rtl/fp_loader.sv | 171 +++++++++++++++++
 tb/tb_fp_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_loader.sv
// fp_loader: streams a program image into SAP-1 memory through the front-panel
// port, optionally reads each word back for comparison, then pulses CPU clear.
module fp_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HOLD   = 2,
  parameter bit          VERIFY = 1'b1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clken,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic              fp_prog,
  output logic              fp_write,
  output logic [ADDR_W-1:0] fp_adr,
  output logic [DATA_W-1:0] fp_data,
  output logic              fp_clear,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_adr
);

  // Tick counter must reach HOLD-1 (WRITE) and 1 (VSET/CLEAR).
  localparam int unsigned CNT_W = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  TWO_LAST  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, VSET, VCMP, CLEAR, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] err_adr_q, err_adr_d;
  logic [DATA_W-1:0] shadow_q [1 << ADDR_W];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      adr_q     <= '0;
      data_q    <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      err_adr_q <= err_adr_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (state_q == RECV && in_valid) begin
      shadow_q[adr_q] <= in_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = '0;
    adr_d     = adr_q;
    data_d    = data_q;
    err_adr_d = err_adr_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = RECV;
          adr_d     = '0;
          err_adr_d = '0;
        end
      end
      RECV: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        tick_d = clken ? tick_q + CNT_W'(1) : tick_q;
        if (clken && tick_q == HOLD_LAST) begin
          tick_d = '0;
          if (adr_q == ADR_LAST) begin
            if (VERIFY) begin
              adr_d   = '0;
              state_d = VSET;
            end else begin
              state_d = CLEAR;
            end
          end else begin
            adr_d   = adr_q + ADDR_W'(1);
            state_d = RECV;
          end
        end
      end
      VSET: begin
        tick_d = clken ? tick_q + CNT_W'(1) : tick_q;
        if (clken && tick_q == TWO_LAST) begin
          tick_d  = '0;
          state_d = VCMP;
        end
      end
      VCMP: begin
        if (rd_data != shadow_q[adr_q]) begin
          state_d   = ERROR;
          err_adr_d = adr_q;
        end else if (adr_q == ADR_LAST) begin
          state_d = CLEAR;
        end else begin
          adr_d   = adr_q + ADDR_W'(1);
          state_d = VSET;
        end
      end
      CLEAR: begin
        tick_d = clken ? tick_q + CNT_W'(1) : tick_q;
        if (clken && tick_q == TWO_LAST) begin
          tick_d  = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fp_prog  = 1'b0;
    fp_write = 1'b0;
    fp_clear = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      RECV: begin
        fp_prog  = 1'b1;
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        fp_prog  = 1'b1;
        fp_write = 1'b1;
        busy     = 1'b1;
      end
      VSET, VCMP: begin
        fp_prog = 1'b1;
        busy    = 1'b1;
      end
      CLEAR: begin
        fp_clear = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      ERROR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign fp_adr  = adr_q;
  assign fp_data = data_q;
  assign err_adr = err_adr_q;

endmodule

// File: tb/tb_fp_loader.sv
// Bench for fp_loader: randomized byte streams against a memory/readback model,
// covering verify pass, verify failure, back-pressure, reset abort and VERIFY=0.
module tb_fp_loader;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int HOLD = 2;

  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic          clken = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] rd_data;
  logic          sel = 1'b0;
  logic          start_a, start_b;

  logic          a_ready, a_prog, a_write, a_clear, a_busy, a_done, a_err;
  logic [AW-1:0] a_adr, a_err_adr;
  logic [DW-1:0] a_data;
  logic          b_ready, b_prog, b_write, b_clear, b_busy, b_done, b_err;
  logic [AW-1:0] b_adr, b_err_adr;
  logic [DW-1:0] b_data;

  logic          w_ready, w_prog, w_write, w_clear, w_busy, w_done, w_err;
  logic [AW-1:0] w_adr, w_err_adr;
  logic [DW-1:0] w_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] img [16];
  bit  corrupt = 1'b0;
  bit  rnd_clk = 1'b0;
  int  cdiv = 0;

  int            wr_adr_q [$];
  logic [DW-1:0] wr_dat_q [$];
  int            hold_q [$];
  int  cur_hold, unstable, rdy_in_wr, wr_noprog, clear_ticks, clear_seen, vgap;
  bit  prev_wr;
  logic [AW-1:0] last_adr;
  logic [DW-1:0] last_dat;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  fp_loader dut_a (
    .sysclk(sysclk), .reset(reset), .clken(clken), .start(start_a),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_ready), .rd_data(rd_data),
    .fp_prog(a_prog), .fp_write(a_write), .fp_adr(a_adr), .fp_data(a_data),
    .fp_clear(a_clear), .busy(a_busy), .done(a_done), .err(a_err), .err_adr(a_err_adr)
  );

  fp_loader #(.DEPTH(4), .VERIFY(1'b0)) dut_b (
    .sysclk(sysclk), .reset(reset), .clken(clken), .start(start_b),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_ready), .rd_data(rd_data),
    .fp_prog(b_prog), .fp_write(b_write), .fp_adr(b_adr), .fp_data(b_data),
    .fp_clear(b_clear), .busy(b_busy), .done(b_done), .err(b_err), .err_adr(b_err_adr)
  );

  assign w_ready   = sel ? b_ready   : a_ready;
  assign w_prog    = sel ? b_prog    : a_prog;
  assign w_write   = sel ? b_write   : a_write;
  assign w_clear   = sel ? b_clear   : a_clear;
  assign w_busy    = sel ? b_busy    : a_busy;
  assign w_done    = sel ? b_done    : a_done;
  assign w_err     = sel ? b_err     : a_err;
  assign w_adr     = sel ? b_adr     : a_adr;
  assign w_err_adr = sel ? b_err_adr : a_err_adr;
  assign w_data    = sel ? b_data    : a_data;

  // Memory readback model; corrupt mode makes address 5 read as 0xFF.
  assign rd_data = (corrupt && w_adr == 4'd5) ? 8'hFF : mem[w_adr];

  initial forever #5 sysclk = ~sysclk;

  initial forever begin
    @(posedge sysclk);
    #1;
    cdiv++;
    clken = rnd_clk ? 1'($urandom_range(0, 1)) : ((cdiv % 4) == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus monitor: memory writes, per-word hold ticks, clear ticks, invariants.
  always @(negedge sysclk) begin
    if (w_write) begin
      if (!prev_wr) begin
        wr_adr_q.push_back(int'(w_adr));
        wr_dat_q.push_back(w_data);
        cur_hold = 0;
      end else if (w_adr !== last_adr || w_data !== last_dat) begin
        unstable++;
      end
      if (clken) cur_hold++;
      if (w_ready) rdy_in_wr++;
      if (!w_prog) wr_noprog++;
      mem[w_adr] = w_data;
    end else if (prev_wr) begin
      hold_q.push_back(cur_hold);
    end
    prev_wr  = w_write;
    last_adr = w_adr;
    last_dat = w_data;
    if (w_clear) begin
      clear_seen++;
      if (clken) clear_ticks++;
    end
    if (w_prog && !w_write && !w_ready) vgap++;
  end

  task automatic clr_mon();
    wr_adr_q.delete();
    wr_dat_q.delete();
    hold_q.delete();
    cur_hold = 0; unstable = 0; rdy_in_wr = 0; wr_noprog = 0;
    clear_ticks = 0; clear_seen = 0; vgap = 0; prev_wr = 1'b0;
  endtask

  // Differences between the observed write log / memory and the n-word image.
  function automatic int log_diff(input int n);
    int d = 0;
    if (wr_adr_q.size() != n || wr_dat_q.size() != n || hold_q.size() != n) return 1000;
    for (int i = 0; i < n; i++) begin
      if (wr_adr_q[i] != i) d++;
      if (wr_dat_q[i] !== img[i]) d++;
      if (hold_q[i] != HOLD) d++;
      if (mem[i] !== img[i]) d++;
    end
    return d + unstable + rdy_in_wr + wr_noprog;
  endfunction

  // First address whose readback would differ from the image, or -1.
  function automatic int model_err_adr(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] rb;
      rb = (corrupt && i == 5) ? 8'hFF : img[i];
      if (rb !== img[i]) return i;
    end
    return -1;
  endfunction

  task automatic pulse_start(input string name);
    clr_mon();
    @(posedge sysclk); #1 start = 1'b1;
    @(posedge sysclk); #1 start = 1'b0;
    @(negedge sysclk);
    checks++;
    if ({w_busy, w_ready, w_done, w_err} !== 4'b1100 || w_adr !== '0) begin
      errors++;
      $display("FAIL %s_start: busy/ready/done/err=%b adr=%0d, required 1100 adr=0",
               name, {w_busy, w_ready, w_done, w_err}, w_adr);
    end
  endtask

  task automatic stream(input int n, input bit rnd);
    int i = 0;
    int cyc = 0;
    bit gapped = 1'b0;
    while (i < n && cyc < 5000) begin
      @(posedge sysclk); #1;
      if (rnd && i == 8 && !gapped) begin
        gapped = 1'b1;
        in_valid = 1'b0;
        repeat (20) @(posedge sysclk);
        #1;
      end
      if (rnd) begin
        in_valid = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b1;
      end
      in_data = in_valid ? img[i] : 8'($urandom);
      @(negedge sysclk);
      if (in_valid && w_ready) i++;
      cyc++;
    end
    @(posedge sysclk); #1;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge sysclk);
      if (w_done || w_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    checks++;
    if ({a_ready, a_prog, a_write, a_clear, a_busy, a_done, a_err, a_adr, a_err_adr, a_data,
         b_ready, b_prog, b_write, b_clear, b_busy, b_done, b_err, b_adr, b_err_adr, b_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a=%b%b%b%b%b%b%b adr=%0d data=%h, required all zero",
               a_ready, a_prog, a_write, a_clear, a_busy, a_done, a_err, a_adr, a_data);
    end
  endtask

  task automatic test_load_verify();
    bit ok;
    int d;
    sel = 1'b0; rnd_clk = 1'b0; corrupt = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    pulse_start("load");
    stream(16, 1'b0);
    wait_end(ok);
    d = log_diff(16);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL load_timeout: finished=%0b, required 1", ok); end
    checks++;
    if (d != 0) begin errors++; $display("FAIL load_log: %0d diffs (writes=%0d), required 0", d, wr_adr_q.size()); end
    checks++;
    if (clear_ticks != 2) begin errors++; $display("FAIL load_clear: %0d ticks, required 2", clear_ticks); end
    checks++;
    if ({w_done, w_err, w_prog} !== 3'b100) begin
      errors++; $display("FAIL load_flags: done/err/prog=%b, required 100", {w_done, w_err, w_prog});
    end
    checks++;
    if (vgap < 32) begin errors++; $display("FAIL load_verify_cycles: %0d, required >= 32", vgap); end
  endtask

  task automatic test_verify_error();
    bit ok;
    int d, exp_adr;
    corrupt = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    if (img[5] == 8'hFF) img[5] = 8'h5A;
    exp_adr = model_err_adr(16);
    pulse_start("from_done");
    stream(16, 1'b0);
    wait_end(ok);
    d = log_diff(16);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL verr_timeout: finished=%0b, required 1", ok); end
    checks++;
    if (d != 0) begin errors++; $display("FAIL verr_log: %0d diffs, required 0", d); end
    checks++;
    if ({w_err, w_done} !== 2'b10 || int'(w_err_adr) != exp_adr) begin
      errors++;
      $display("FAIL verr_flags: err/done=%b err_adr=%0d, required 10 err_adr=%0d",
               {w_err, w_done}, w_err_adr, exp_adr);
    end
    checks++;
    if (clear_seen != 0) begin errors++; $display("FAIL verr_clear: %0d clear cycles, required 0", clear_seen); end
    corrupt = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int d;
    rnd_clk = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    pulse_start("from_error");
    stream(16, 1'b1);
    wait_end(ok);
    d = log_diff(16);
    checks++;
    if (ok !== 1'b1 || w_done !== 1'b1) begin
      errors++; $display("FAIL bp_done: finished=%0b done=%b, required 1 1", ok, w_done);
    end
    checks++;
    if (d != 0) begin errors++; $display("FAIL bp_log: %0d diffs (writes=%0d), required 0", d, wr_adr_q.size()); end
    checks++;
    if (clear_ticks != 2) begin errors++; $display("FAIL bp_clear: %0d ticks, required 2", clear_ticks); end
    rnd_clk = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok, hit;
    int d;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    pulse_start("abort");
    stream(8, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge sysclk);
      if (w_write && w_adr == 4'd7) begin hit = 1'b1; break; end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach: write of adr 7 seen=%0b, required 1", hit); end
    reset = 1'b1;
    @(negedge sysclk);
    checks++;
    if ({w_ready, w_prog, w_write, w_clear, w_busy, w_done, w_err, w_adr, w_data, w_err_adr} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: prog/write/busy=%b%b%b adr=%0d data=%h, required all zero",
               w_prog, w_write, w_busy, w_adr, w_data);
    end
    reset = 1'b0;
    pulse_start("reload");
    stream(16, 1'b0);
    wait_end(ok);
    d = log_diff(16);
    checks++;
    if (ok !== 1'b1 || w_done !== 1'b1 || d != 0) begin
      errors++; $display("FAIL reload: finished=%0b done=%b diffs=%0d, required 1 1 0", ok, w_done, d);
    end
  endtask

  task automatic test_no_verify();
    bit ok;
    int d;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    pulse_start("nv");
    stream(4, 1'b0);
    wait_end(ok);
    d = log_diff(4);
    checks++;
    if (ok !== 1'b1 || {w_done, w_err} !== 2'b10) begin
      errors++; $display("FAIL nv_done: finished=%0b done/err=%b, required 1 10", ok, {w_done, w_err});
    end
    checks++;
    if (d != 0) begin errors++; $display("FAIL nv_log: %0d diffs (writes=%0d), required 0", d, wr_adr_q.size()); end
    checks++;
    if (vgap != 0 || clear_ticks != 2) begin
      errors++; $display("FAIL nv_seq: verify cycles=%0d clear ticks=%0d, required 0 2", vgap, clear_ticks);
    end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    clr_mon();
    test_reset();
    test_load_verify();
    test_verify_error();
    test_backpressure();
    test_reset_abort();
    test_no_verify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
